// File: rtl/lif_membrane_if.sv
// Signal bundle between the batch-normalization stage and the LIF membrane.
// The master drives the neuron inputs, and the slave (the neuron) returns its state.
interface lif_membrane_if #(
  parameter int WIDTH        = 6,
  parameter int REFRAC_WIDTH = 3
);
  logic                    ena;
  logic signed [WIDTH-1:0] bn_in;
  logic [WIDTH-2:0]        threshold;
  logic [1:0]              leak_shift;
  logic                    reset_mode;
  logic [REFRAC_WIDTH-1:0] refrac_period;
  logic signed [WIDTH-1:0] u_fb;
  logic signed [WIDTH-1:0] membrane;
  logic                    spike;
  logic                    refractory;
  logic [7:0]              spike_count;

  modport master (
    output ena, bn_in, threshold, leak_shift, reset_mode, refrac_period,
    input  u_fb, membrane, spike, refractory, spike_count
  );

  modport slave (
    input  ena, bn_in, threshold, leak_shift, reset_mode, refrac_period,
    output u_fb, membrane, spike, refractory, spike_count
  );
endinterface

// File: rtl/lif_membrane.sv
// Leaky integrate-and-fire membrane: threshold compare, reset, leak feedback and spike counting.
// Optional refractory counter is enabled by defining LIF_REFRACTORY_EN.
module lif_membrane #(
  parameter int WIDTH        = 6,
  parameter int REFRAC_WIDTH = 3
) (
  input logic           clk,
  input logic           rst_n,
  lif_membrane_if.slave bus
);

  function automatic logic signed [WIDTH-1:0] leak(input logic signed [WIDTH-1:0] u,
                                                   input logic [1:0] sh);
    logic signed [WIDTH-1:0] r;
    if (sh == 2'd0) r = u;
    else            r = u - (u >>> sh);
    return r;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  logic signed [WIDTH-1:0] membrane_p0;
  logic                    spike_p0;
  logic [7:0]              count_p0;
  logic signed [WIDTH-1:0] thr_ext;
  logic                    in_refrac;
  logic                    fire;
  logic signed [WIDTH-1:0] membrane_nxt;

  assign thr_ext = $signed({1'b0, bus.threshold});
  assign fire    = ~in_refrac & (bus.bn_in >= thr_ext);

  always_comb begin
    membrane_nxt = bus.bn_in;
    if (in_refrac)           membrane_nxt = membrane_p0;
    else if (fire)           membrane_nxt = bus.reset_mode ? '0 : bus.bn_in - thr_ext;
  end

  // Stage p0: membrane state, spike flag and spike counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      membrane_p0 <= '0;
      spike_p0    <= 1'b0;
      count_p0    <= '0;
    end else if (bus.ena) begin
      membrane_p0 <= membrane_nxt;
      spike_p0    <= fire;
      if (fire) count_p0 <= sat_inc(count_p0);
    end
  end

`ifdef LIF_REFRACTORY_EN
  logic [REFRAC_WIDTH-1:0] refrac_cnt_p0;

  assign in_refrac = |refrac_cnt_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          refrac_cnt_p0 <= '0;
    else if (bus.ena) begin
      if (in_refrac)     refrac_cnt_p0 <= refrac_cnt_p0 - REFRAC_WIDTH'(1);
      else if (fire)     refrac_cnt_p0 <= bus.refrac_period;
    end
  end
`else
  logic unused_refrac_period;

  assign in_refrac            = 1'b0;
  assign unused_refrac_period = ^bus.refrac_period;
`endif

  assign bus.u_fb        = leak(membrane_p0, bus.leak_shift);
  assign bus.membrane    = membrane_p0;
  assign bus.spike       = spike_p0;
  assign bus.refractory  = in_refrac;
  assign bus.spike_count = count_p0;

endmodule
